// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM encoding, gap length
// and the default requester count.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int GAP_CYCLES  = 2;
  localparam int NUM_REQ_DEF = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Rotate-priority encoder: returns the first set req_valid bit at or after
// rr_ptr, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [REQ_W-1:0]   rr_ptr_i,
  output logic               found_o,
  output logic [REQ_W-1:0]   idx_o
);

  always_comb begin
    int cand;
    cand    = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr_i) + i) % NUM_REQ;
      if (!found_o && req_valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand[REQ_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter between
// NUM_REQ byte streams. Optional idle-owner timeout: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int REQ_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [REQ_W-1:0]     grant_id,
`ifdef UART_TX_ARB_TIMEOUT_EN
  output logic                 timeout_flag,
`endif
  output state_t               dbg_state_o
);

  if (REQ_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  // Handshake: a requester byte transfers on a rising edge where
  // req_valid[i] & req_ready[i]; only the owner ever sees ready, and only in SEND.
  state_t           state_q, state_d;
  logic [REQ_W-1:0] owner_q, owner_d;
  logic [REQ_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic             strobe_q, strobe_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [1:0]       gap_q, gap_d;

  logic             pick_found;
  logic [REQ_W-1:0] pick_idx;
  logic [REQ_W-1:0] next_ptr;
  logic             owner_valid;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_picker (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .found_o     (pick_found),
    .idx_o       (pick_idx)
  );

  assign owner_valid = req_valid[owner_q];
  assign next_ptr    = (owner_q == REQ_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    last_d    = last_q;
    grant_d   = grant_q;
    strobe_d  = 1'b0;
    tx_data_d = tx_data_q;
    gap_d     = gap_q;
    req_ready = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        req_ready[owner_q] = !tx_busy;
        if (owner_valid && !tx_busy) begin
          tx_data_d = req_data[{owner_q, 3'b000} +: 8];
          strobe_d  = 1'b1;
          last_d    = req_last[owner_q];
          gap_d     = '0;
          state_d   = ST_GAP;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt_d  = '0;
        end else if (!owner_valid) begin
          // A silent owner loses the lock as though its packet had ended.
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_d  = '0;
            to_flag_d = 1'b1;
            grant_d   = 1'b0;
            rr_ptr_d  = next_ptr;
            state_d   = ST_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end
      ST_GAP: begin
        // Second gap cycle lets the UART's tx_busy become visible before SEND.
        if (gap_q == 2'(GAP_CYCLES - 1)) begin
          if (last_q) begin
            grant_d  = 1'b0;
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      last_q    <= 1'b0;
      grant_q   <= 1'b0;
      strobe_q  <= 1'b0;
      tx_data_q <= '0;
      gap_q     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      strobe_q  <= strobe_d;
      tx_data_q <= tx_data_d;
      gap_q     <= gap_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
`endif
    end
  end

  assign tx_data      = tx_data_q;
  assign new_tx_data  = strobe_q;
  assign grant_active = grant_q;
  assign grant_id     = owner_q;
  assign dbg_state_o  = state_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_flag = to_flag_q;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (tx_data / new_tx_data / tx_busy handshake) between NUM_REQ byte-stream requesters, e.g. several message printers plus a debug echo path.
- Arbitration is round-robin at packet granularity. The winner holds the transmitter until it delivers a byte flagged req_last, so messages never interleave.
- Sits between the message sources and the serial transmitter in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 1024, idle-owner timeout; used only with the optional feature.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- req_valid  input  NUM_REQ  per-requester: byte available.
- req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NUM_REQ  per-requester: current byte ends the packet.
- req_ready  output  NUM_REQ  per-requester: byte accepted this cycle when valid&ready.
- tx_data  output  8  byte to UART transmitter, registered.
- new_tx_data  output  1  one-cycle strobe to UART transmitter, registered.
- tx_busy  input  1  UART transmitter busy.
- grant_active  output  1  a requester currently owns the transmitter.
- grant_id  output  REQ_W  index of the owner; valid only when grant_active=1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_data=0, new_tx_data=0, req_ready=0, grant_active=0, grant_id=0, rr_ptr=0, gap counter=0. Reset mid-packet abandons the packet. No strobe is emitted while rst=0 or in the first cycle after release.
- States: IDLE, SEND, GAP.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; take the first set bit.
  - If found: latch owner, grant_active<=1, grant_id<=owner, go to SEND.
  - Grant costs one cycle; req_ready is 0 in IDLE.
- SEND:
  - req_ready[owner] = !tx_busy (combinational); all other req_ready bits are 0.
  - On req_valid[owner] & req_ready[owner]:
    - tx_data<=req_data[owner], new_tx_data<=1 next cycle (latency 1 from accept to strobe).
    - Go to GAP.
    - Capture req_last into a last-flag.
- GAP:
  - Two cycles with req_ready=0: the strobe cycle, then one more so the UART's tx_busy is visible.
  - Then, if last-flag is set: grant_active<=0, rr_ptr<=(owner+1) mod NUM_REQ, go to IDLE. Otherwise return to SEND.
- Minimum spacing between strobes is 3 cycles.
- new_tx_data is high for exactly one cycle per accepted byte. tx_data holds its value until the next accept.
- Owner drops req_valid mid-packet: lock is held and the block waits indefinitely (unless the timeout feature is enabled).
- tx_busy stuck high: block waits in SEND; no bytes are lost.
- Single-byte packet (valid&last in the first SEND cycle): follows the normal path back to IDLE after GAP.
- Simultaneous requests: rotation guarantees each waiting requester is served within NUM_REQ packets.
- The lone requester is re-granted immediately after its own packet.
- Non-owner requesters see req_ready=0 and must hold their data stable.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro: in SEND, a counter increments each cycle that req_valid[owner]=0 and clears on any accept. At TIMEOUT_CYCLES the lock is dropped as if the packet had ended: rr_ptr advances, go to IDLE. A sticky timeout_flag output (1 bit, cleared only by reset) records that this happened.
- Without the macro: no counter, no timeout_flag port; the lock is held until req_last.

Decomposition:
- Shared package uart_arb_pkg holds:
  - state encoding constants ST_IDLE=0, ST_SEND=1, ST_GAP=2 (2-bit);
  - GAP_CYCLES=2;
  - default NUM_REQ.
- One natural sub-module, rr_picker: combinational rotate-priority encoder. Inputs req_valid and rr_ptr; outputs found and the index.

Test Plan:
- Reset then requester 1 sends "Hi" (last on 'i'): grant in 1 cycle, grant_id=1; strobes carry 0x48 then 0x69, ≥3 cycles apart; grant_active drops after GAP; rr_ptr=2.
- Requesters 0 and 2 assert valid together with 3-byte packets: all bytes of 0 go out before any of 2; next contention with rr_ptr=1 serves 2 before 0.
- tx_busy held high for 50 cycles after a grant: req_ready=0 and no strobe throughout. On release, the byte is accepted in the first cycle tx_busy=0 and the strobe follows one cycle later.
- Owner 3 drops valid for 20 cycles mid-packet while requester 0 is waiting: no grant change. With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, release occurs at cycle 16, grant_id=0, timeout_flag=1.
- rst pulsed low during GAP of a packet: all outputs are 0 immediately (asynchronous). After release, no strobe occurs until a fresh grant from rr_ptr=0.
- Lone requester 0 sends two back-to-back 1-byte packets: grant, strobe, IDLE, re-grant to 0; exactly two strobes.
